eco32_core_lsu_dcm_ptx: RTL and testbench

Packet transmitter for the LSU data-cache-memory outbound path. It drains the header/payload buffer stage of the DCM packet FIFO and acknowledges headers and flushes payload words. It serializes each packet onto the memory-network link through a single registered output stage with ready backpressure. It also frames packets (start/end markers), counts transmitted packets and flags protocol violations.

---
 rtl/eco32_core_lsu_dcm_pkg.sv | 23 ++
 rtl/eco32_core_lsu_dcm_ptx_oreg.sv | 44 ++++
 rtl/eco32_core_lsu_dcm_ptx.sv | 129 ++++++++++++
 tb/tb_eco32_core_lsu_dcm_ptx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/eco32_core_lsu_dcm_pkg.sv
// Shared DCM packet types and constants: FSM encoding, word/iid widths,
// header length-field position and the length clip helper.
package eco32_core_lsu_dcm_pkg;

  localparam int DCM_WORD_W      = 72;
  localparam int DCM_IID_W       = 4;
  localparam int DCM_LEN_W       = 4;
  localparam int DCM_HDR_LEN_MSB = 67;
  localparam int DCM_HDR_LEN_LSB = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLD  = 1'b1
  } ptx_state_e;

  function automatic logic [DCM_LEN_W-1:0] dcm_clip_len(
    input logic [DCM_LEN_W-1:0] len,
    input logic [DCM_LEN_W-1:0] max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/eco32_core_lsu_dcm_ptx_oreg.sv
// Single registered link stage: loads on demand, drops valid once the link
// takes the word, and reports whether it can accept a new word this cycle.
module eco32_core_lsu_dcm_ptx_oreg
  import eco32_core_lsu_dcm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  ld_sof,
  input  logic                  ld_eof,
  input  logic [DCM_WORD_W-1:0] ld_data,
  input  logic [DCM_IID_W-1:0]  ld_iid,
  input  logic                  o_rdy,
  output logic                  free,
  output logic                  o_stb,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [DCM_WORD_W-1:0] o_data,
  output logic [DCM_IID_W-1:0]  o_iid
);

  // Handshake: a word transfers on o_stb && o_rdy; while o_stb && !o_rdy the
  // register holds all fields and refuses new loads.
  assign free = !o_stb || o_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stb  <= 1'b0;
      o_sof  <= 1'b0;
      o_eof  <= 1'b0;
      o_data <= '0;
      o_iid  <= '0;
    end else if (load) begin
      o_stb  <= 1'b1;
      o_sof  <= ld_sof;
      o_eof  <= ld_eof;
      o_data <= ld_data;
      o_iid  <= ld_iid;
    end else if (o_rdy) begin
      o_stb  <= 1'b0;
    end
  end

endmodule

// File: rtl/eco32_core_lsu_dcm_ptx.sv
// DCM outbound packet transmitter: drains header/payload words into one framed
// link stage. Optional payload id check: ECO32_DCM_PTX_IID_CHECK_EN.
module eco32_core_lsu_dcm_ptx
  import eco32_core_lsu_dcm_pkg::*;
#(
  parameter int PKT_MAX_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hdr_stb,
  output logic                  i_hdr_ack,
  input  logic                  i_data_stb,
  output logic                  i_data_flush,
  input  logic [DCM_WORD_W-1:0] i_data,
  input  logic [DCM_IID_W-1:0]  i_iid,
  output logic                  o_stb,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [DCM_WORD_W-1:0] o_data,
  output logic [DCM_IID_W-1:0]  o_iid,
  input  logic                  o_rdy,
  output logic                  o_err,
  output logic [15:0]           o_pkt_cnt,
  output ptx_state_e            dbg_state
);

  localparam logic [DCM_LEN_W-1:0] MAX_LEN = DCM_LEN_W'(PKT_MAX_LEN);

  ptx_state_e           state, state_nxt;
  logic [DCM_LEN_W-1:0] rem, rem_nxt;
  logic [DCM_LEN_W-1:0] hdr_len, len_clip;
  logic                 free, load, ld_sof, ld_eof, err_set;
  logic [DCM_IID_W-1:0] ld_iid;
`ifdef ECO32_DCM_PTX_IID_CHECK_EN
  logic [DCM_IID_W-1:0] pkt_iid;
`endif

  assign hdr_len   = i_data[DCM_HDR_LEN_MSB:DCM_HDR_LEN_LSB];
  assign len_clip  = dcm_clip_len(hdr_len, MAX_LEN);
  assign dbg_state = state;

  // Acks are gated by rst_n so upstream sees none while reset is held.
  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    load         = 1'b0;
    ld_sof       = 1'b0;
    ld_eof       = 1'b0;
    ld_iid       = i_iid;
    i_hdr_ack    = 1'b0;
    i_data_flush = 1'b0;
    err_set      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_hdr_stb) begin
          i_hdr_ack = rst_n && free;
          if (i_hdr_ack) begin
            load    = 1'b1;
            ld_sof  = 1'b1;
            ld_eof  = (len_clip == '0);
            rem_nxt = len_clip;
            err_set = (hdr_len > MAX_LEN);
            if (len_clip != '0) state_nxt = ST_PLD;
          end
        end else if (i_data_stb) begin
          // Stray payload outside a frame is discarded, never transmitted.
          i_data_flush = rst_n && free;
          err_set      = 1'b1;
        end
      end
      ST_PLD: begin
        err_set = i_hdr_stb;
        if (i_data_stb) begin
          i_data_flush = rst_n && free;
          if (i_data_flush) begin
            load    = 1'b1;
            ld_eof  = (rem == 4'd1);
            rem_nxt = rem - 4'd1;
            if (rem == 4'd1) state_nxt = ST_IDLE;
`ifdef ECO32_DCM_PTX_IID_CHECK_EN
            ld_iid = pkt_iid;
            if (i_iid != pkt_iid) err_set = 1'b1;
`endif
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rem       <= '0;
      o_err     <= 1'b0;
      o_pkt_cnt <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (err_set) o_err <= 1'b1;
      if (o_stb && o_rdy && o_eof) o_pkt_cnt <= o_pkt_cnt + 16'd1;
    end
  end

`ifdef ECO32_DCM_PTX_IID_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pkt_iid <= '0;
    else if (i_hdr_ack) pkt_iid <= i_iid;
  end
`endif

  eco32_core_lsu_dcm_ptx_oreg u_oreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ld_sof  (ld_sof),
    .ld_eof  (ld_eof),
    .ld_data (i_data),
    .ld_iid  (ld_iid),
    .o_rdy   (o_rdy),
    .free    (free),
    .o_stb   (o_stb),
    .o_sof   (o_sof),
    .o_eof   (o_eof),
    .o_data  (o_data),
    .o_iid   (o_iid)
  );

endmodule

// File: tb/tb_eco32_core_lsu_dcm_ptx.sv
// Directed bench for the DCM packet transmitter: framing, backpressure,
// protocol errors, length clipping, id tagging and mid-frame reset.
module tb_eco32_core_lsu_dcm_ptx;
  import eco32_core_lsu_dcm_pkg::*;

  logic        clk, rst_n;
  logic        i_hdr_stb, i_hdr_ack, i_data_stb, i_data_flush;
  logic [71:0] i_data, o_data;
  logic [3:0]  i_iid, o_iid;
  logic        o_stb, o_sof, o_eof, o_rdy, o_err;
  logic [15:0] o_pkt_cnt;
  ptx_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [71:0] hdr;

  eco32_core_lsu_dcm_ptx #(.PKT_MAX_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_hdr_stb(i_hdr_stb), .i_hdr_ack(i_hdr_ack),
    .i_data_stb(i_data_stb), .i_data_flush(i_data_flush),
    .i_data(i_data), .i_iid(i_iid),
    .o_stb(o_stb), .o_sof(o_sof), .o_eof(o_eof),
    .o_data(o_data), .o_iid(o_iid), .o_rdy(o_rdy),
    .o_err(o_err), .o_pkt_cnt(o_pkt_cnt), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every step lands 1ns after the active edge; inputs change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk_hdr(input logic [3:0] len, input logic [63:0] tag);
    return {4'h0, len, tag};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stb"},   72'(o_stb), 72'(0));
    chk({tag, "_sof"},   72'(o_sof), 72'(0));
    chk({tag, "_eof"},   72'(o_eof), 72'(0));
    chk({tag, "_data"},  o_data, 72'(0));
    chk({tag, "_iid"},   72'(o_iid), 72'(0));
    chk({tag, "_err"},   72'(o_err), 72'(0));
    chk({tag, "_cnt"},   72'(o_pkt_cnt), 72'(0));
    chk({tag, "_ack"},   72'(i_hdr_ack), 72'(0));
    chk({tag, "_flush"}, 72'(i_data_flush), 72'(0));
    chk({tag, "_state"}, 72'(dbg_state), 72'(ST_IDLE));
  endtask

  initial begin
    i_hdr_stb = 0; i_data_stb = 0; i_data = '0; i_iid = '0; o_rdy = 1; rst_n = 0;
    #2;
    i_hdr_stb = 1;
    #1;
    chk_reset_vals("rst");
    i_hdr_stb = 0;
    tick(); tick();
    rst_n = 1;
    tick();

    // len=3, three back-to-back payload words
    hdr = mk_hdr(4'd3, 64'h1111);
    i_hdr_stb = 1; i_data = hdr; i_iid = 4'd2;
    #1; chk("s1_ack", 72'(i_hdr_ack), 72'(1)); chk("s1_flush0", 72'(i_data_flush), 72'(0));
    tick();
    chk("s1_h_stb", 72'(o_stb), 72'(1)); chk("s1_h_sof", 72'(o_sof), 72'(1));
    chk("s1_h_eof", 72'(o_eof), 72'(0)); chk("s1_h_data", o_data, hdr);
    chk("s1_h_iid", 72'(o_iid), 72'(2)); chk("s1_h_state", 72'(dbg_state), 72'(ST_PLD));
    i_hdr_stb = 0; i_data_stb = 1;
    for (int k = 1; k <= 3; k++) begin
      i_data = 72'(k * 257);
      #1; chk("s1_flush", 72'(i_data_flush), 72'(1)); chk("s1_noack", 72'(i_hdr_ack), 72'(0));
      tick();
      chk("s1_p_data", o_data, 72'(k * 257)); chk("s1_p_sof", 72'(o_sof), 72'(0));
      chk("s1_p_eof", 72'(o_eof), 72'(k == 3)); chk("s1_p_stb", 72'(o_stb), 72'(1));
    end
    i_data_stb = 0;
    #1; chk("s1_flush_end", 72'(i_data_flush), 72'(0)); chk("s1_cnt0", 72'(o_pkt_cnt), 72'(0));
    tick();
    chk("s1_cnt1", 72'(o_pkt_cnt), 72'(1)); chk("s1_idle_stb", 72'(o_stb), 72'(0));
    chk("s1_state", 72'(dbg_state), 72'(ST_IDLE));

    // len=0: header-only frame
    hdr = mk_hdr(4'd0, 64'h2222);
    i_hdr_stb = 1; i_data = hdr; i_iid = 4'd3;
    #1; chk("s2_ack", 72'(i_hdr_ack), 72'(1));
    tick();
    chk("s2_sof", 72'(o_sof), 72'(1)); chk("s2_eof", 72'(o_eof), 72'(1));
    chk("s2_stb", 72'(o_stb), 72'(1)); chk("s2_state", 72'(dbg_state), 72'(ST_IDLE));
    i_hdr_stb = 0;
    tick();
    chk("s2_cnt", 72'(o_pkt_cnt), 72'(2)); chk("s2_stb_off", 72'(o_stb), 72'(0));

    // len=2 with 5 cycles of backpressure after the header
    hdr = mk_hdr(4'd2, 64'h3333);
    i_hdr_stb = 1; i_data = hdr; i_iid = 4'd4;
    #1; chk("s3_ack", 72'(i_hdr_ack), 72'(1));
    tick();
    o_rdy = 0; i_hdr_stb = 0; i_data_stb = 1; i_data = 72'hAA;
    #1; chk("s3_bp_flush0", 72'(i_data_flush), 72'(0));
    repeat (5) begin
      tick();
      chk("s3_bp_data", o_data, hdr); chk("s3_bp_sof", 72'(o_sof), 72'(1));
      chk("s3_bp_stb", 72'(o_stb), 72'(1)); chk("s3_bp_flush", 72'(i_data_flush), 72'(0));
    end
    o_rdy = 1;
    #1; chk("s3_resume_flush", 72'(i_data_flush), 72'(1));
    tick();
    chk("s3_p1_data", o_data, 72'hAA); chk("s3_p1_eof", 72'(o_eof), 72'(0));
    i_data = 72'hBB;
    #1; chk("s3_p2_flush", 72'(i_data_flush), 72'(1));
    tick();
    chk("s3_p2_data", o_data, 72'hBB); chk("s3_p2_eof", 72'(o_eof), 72'(1));
    i_data_stb = 0;
    tick();
    chk("s3_cnt", 72'(o_pkt_cnt), 72'(3));

    // stray payload word in IDLE
    i_data_stb = 1; i_data = 72'hCC;
    #1; chk("s4_flush", 72'(i_data_flush), 72'(1)); chk("s4_err_pre", 72'(o_err), 72'(0));
    tick();
    i_data_stb = 0;
    #1; chk("s4_flush_off", 72'(i_data_flush), 72'(0));
    chk("s4_stb", 72'(o_stb), 72'(0)); chk("s4_err", 72'(o_err), 72'(1));
    tick();
    chk("s4_err_sticky", 72'(o_err), 72'(1)); chk("s4_cnt", 72'(o_pkt_cnt), 72'(3));

    // reset asserted mid-frame with both strobes high
    hdr = mk_hdr(4'd2, 64'h5555);
    i_hdr_stb = 1; i_data = hdr; i_iid = 4'd1;
    #1; chk("s5_ack", 72'(i_hdr_ack), 72'(1));
    tick();
    i_hdr_stb = 0; i_data_stb = 1; i_data = 72'hDD;
    tick();
    i_hdr_stb = 1;
    rst_n = 0;
    #1;
    chk_reset_vals("s5_rst");
    i_hdr_stb = 0; i_data_stb = 0;
    #2; rst_n = 1;
    tick();

    // len=12 clipped to 8 payload words
    hdr = mk_hdr(4'd12, 64'h6666);
    i_hdr_stb = 1; i_data = hdr; i_iid = 4'd1;
    #1; chk("s6_ack", 72'(i_hdr_ack), 72'(1)); chk("s6_err_pre", 72'(o_err), 72'(0));
    tick();
    chk("s6_err", 72'(o_err), 72'(1)); chk("s6_state", 72'(dbg_state), 72'(ST_PLD));
    i_hdr_stb = 0; i_data_stb = 1;
    for (int k = 1; k <= 8; k++) begin
      i_data = 72'(k + 16);
      #1; chk("s6_flush", 72'(i_data_flush), 72'(1));
      tick();
      chk("s6_data", o_data, 72'(k + 16)); chk("s6_eof", 72'(o_eof), 72'(k == 8));
    end
    i_data_stb = 0;
    chk("s6_state_end", 72'(dbg_state), 72'(ST_IDLE));
    tick();
    chk("s6_cnt", 72'(o_pkt_cnt), 72'(1));

    // payload id differing from header id
    rst_n = 0;
    #2; rst_n = 1;
    tick();
    chk("s7_err_clr", 72'(o_err), 72'(0));
    hdr = mk_hdr(4'd1, 64'h7777);
    i_hdr_stb = 1; i_data = hdr; i_iid = 4'd5;
    #1; chk("s7_ack", 72'(i_hdr_ack), 72'(1));
    tick();
    i_hdr_stb = 0; i_data_stb = 1; i_data = 72'hEE; i_iid = 4'd6;
    #1; chk("s7_flush", 72'(i_data_flush), 72'(1));
    tick();
    chk("s7_data", o_data, 72'hEE); chk("s7_eof", 72'(o_eof), 72'(1));
`ifdef ECO32_DCM_PTX_IID_CHECK_EN
    chk("s7_iid", 72'(o_iid), 72'(5)); chk("s7_err", 72'(o_err), 72'(1));
`else
    chk("s7_iid", 72'(o_iid), 72'(6)); chk("s7_err", 72'(o_err), 72'(0));
`endif
    i_data_stb = 0;
    tick();
    chk("s7_cnt", 72'(o_pkt_cnt), 72'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
